// File: rtl/aud_record.sv
// aud_record: captures one ADC sample per LR-clock rising edge into memory via write/ready; optional gain under REC_GAIN_EN
module aud_record #(
  parameter int ADDR_W = 26
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_adclrck,
  input  logic [15:0]       i_adc_data,
  input  logic [1:0]        i_gain_shift,
  input  logic [ADDR_W-1:0] i_addr_max,
  input  logic              i_mem_rdy,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_data,
  output logic [ADDR_W-1:0] o_addr_end,
  output logic              o_recording,
  output logic              o_overrun,
  output logic              o_done
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE, PAUSE} state_t;

  state_t            state_q, state_d;
  logic              prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              write_q, write_d;
  logic              overrun_q, overrun_d;
  logic              done_q, done_d;
  logic              rec_q, rec_d;
  logic              stop_q, stop_d;
  logic              pause_q, pause_d;
  logic              edge_s;
  logic [15:0]       sample;

  assign edge_s = !prev_q && i_adclrck;

`ifdef REC_GAIN_EN
  logic signed [18:0] ext, shifted;
  // sign-extend, shift by the gain and clamp to the 16-bit signed range
  always_comb begin
    ext     = {{3{i_adc_data[15]}}, i_adc_data};
    shifted = ext <<< i_gain_shift;
    sample  = shifted > 19'sd32767 ? 16'h7fff :
              shifted < -19'sd32768 ? 16'h8000 : shifted[15:0];
  end
`else
  logic unused_gain;
  assign unused_gain = ^i_gain_shift;
  assign sample      = i_adc_data;
`endif

  // next-state and output logic; stop/pause seen during a write are held until the memory accepts it
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    stop_d    = stop_q;
    pause_d   = pause_q;
    case (state_q)
      IDLE: if (i_start) begin
        addr_d    = '0;
        overrun_d = 1'b0;
        if (i_addr_max == '0) done_d = 1'b1;
        else state_d = WAIT;
      end
      WAIT: if (i_stop) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (i_pause) begin
        state_d = PAUSE;
      end else if (edge_s) begin
        data_d  = sample;
        write_d = 1'b1;
        stop_d  = 1'b0;
        pause_d = 1'b0;
        state_d = WRITE;
      end
      WRITE: begin
        if (edge_s) overrun_d = 1'b1;
        if (i_mem_rdy) begin
          write_d = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          stop_d  = 1'b0;
          pause_d = 1'b0;
          state_d = (addr_d == i_addr_max || i_stop || stop_q) ? IDLE :
                    (i_pause || pause_q) ? PAUSE : WAIT;
          done_d  = state_d == IDLE;
        end else begin
          stop_d  = stop_q | i_stop;
          pause_d = pause_q | i_pause;
        end
      end
      PAUSE: if (i_stop) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (i_start) begin
        state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
    rec_d = state_d == WAIT || state_d == WRITE;
  end

  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      prev_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      rec_q     <= 1'b0;
      stop_q    <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= i_adclrck;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      rec_q     <= rec_d;
      stop_q    <= stop_d;
      pause_q   <= pause_d;
    end
  end

  assign o_mem_write = write_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_data  = data_q;
  assign o_addr_end  = addr_q;
  assign o_recording = rec_q;
  assign o_overrun   = overrun_q;
  assign o_done      = done_q;
endmodule

// File: tb/tb_aud_record.sv
// tb_aud_record: randomized and directed scoreboard bench for aud_record
module tb_aud_record;
  localparam int M_IDLE = 0, M_WAIT = 1, M_WRITE = 2, M_PAUSE = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_start = 0, i_pause = 0, i_stop = 0, i_adclrck = 0, i_mem_rdy = 0;
  logic [15:0] i_adc_data = 0;
  logic [1:0]  i_gain_shift = 0;
  logic [25:0] i_addr_max = 0;
  logic        o_mem_write, o_recording, o_overrun, o_done;
  logic [25:0] o_mem_addr, o_addr_end;
  logic [15:0] o_mem_data;

  aud_record dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .i_adclrck(i_adclrck), .i_adc_data(i_adc_data), .i_gain_shift(i_gain_shift),
    .i_addr_max(i_addr_max), .i_mem_rdy(i_mem_rdy), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_addr_end(o_addr_end),
    .o_recording(o_recording), .o_overrun(o_overrun), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [47:0] exp_q[$];
  int m_mode = M_IDLE, m_addr = 0, amax = 0;
  logic m_ovr = 0, m_prev = 0, m_sp = 0, m_pp = 0, e_done = 0, wr_prev = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gain(logic [15:0] d, logic [1:0] sh);
`ifdef REC_GAIN_EN
    int v;
    v = $signed(d);
    v = v * (1 << sh);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
`else
    return d;
`endif
  endfunction

  // monitor: every newly raised write request is matched against the scoreboard
  always @(negedge clk) begin
    if (o_mem_write && !wr_prev) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(o_mem_addr), 32'hffffffff);
      else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(o_mem_addr), e[47:16]);
        chk("write_data", 32'(o_mem_data), 32'(e[15:0]));
      end
    end
    wr_prev = o_mem_write;
  end

  task automatic cyc(logic st, logic pa, logic sp, logic lr, logic [15:0] d, logic [1:0] sh, logic rdy);
    logic edge_e;
    @(negedge clk);
    chk("done", 32'(o_done), 32'(e_done));
    chk("addr_end", 32'(o_addr_end), m_addr);
    chk("overrun", 32'(o_overrun), 32'(m_ovr));
    chk("recording", 32'(o_recording), 32'(m_mode == M_WAIT || m_mode == M_WRITE));
    chk("mem_write", 32'(o_mem_write), 32'(m_mode == M_WRITE));
    i_start = st; i_pause = pa; i_stop = sp; i_adclrck = lr; i_adc_data = d;
    i_gain_shift = sh; i_mem_rdy = rdy; i_addr_max = 26'(amax);
    edge_e = !m_prev && lr;
    m_prev = lr;
    e_done = 0;
    case (m_mode)
      M_IDLE: if (st) begin
        m_addr = 0; m_ovr = 0;
        if (amax == 0) e_done = 1; else m_mode = M_WAIT;
      end
      M_WAIT: if (sp) begin m_mode = M_IDLE; e_done = 1; end
        else if (pa) m_mode = M_PAUSE;
        else if (edge_e) begin
          exp_q.push_back({32'(m_addr), gain(d, sh)});
          m_mode = M_WRITE; m_sp = 0; m_pp = 0;
        end
      M_WRITE: begin
        if (edge_e) m_ovr = 1;
        if (rdy) begin
          m_addr++;
          if (m_addr == amax || sp || m_sp) begin m_mode = M_IDLE; e_done = 1; end
          else m_mode = (pa || m_pp) ? M_PAUSE : M_WAIT;
        end else begin
          m_sp |= sp; m_pp |= pa;
        end
      end
      default: if (sp) begin m_mode = M_IDLE; e_done = 1; end
        else if (st) m_mode = M_WAIT;
    endcase
  endtask

  task automatic idle(int n, logic rdy = 0);
    repeat (n) cyc(0, 0, 0, 0, 16'h0, 2'd0, rdy);
  endtask

  task automatic cap(logic [15:0] d, logic [1:0] sh, int lat);
    cyc(0, 0, 0, 1, d, sh, 0);
    idle(lat);
    idle(1, 1);
  endtask

  initial begin
    idle(2);
    rst_n = 1'b1;
    idle(2);
    // basic capture
    amax = 3;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cap(16'h0001, 0, 0); cap(16'h7fff, 0, 0); cap(16'h8000, 0, 0);
    idle(3);
    // overrun
    amax = 4;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h1111, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h2222, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    // stop during write
    amax = 8;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h1234, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    idle(1, 1);
    idle(3);
    // pause and resume
    amax = 10;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cap(16'h0a0a, 0, 1); cap(16'h0b0b, 0, 2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (4) begin cyc(0, 0, 0, 1, 16'hdead, 0, 0); cyc(0, 0, 0, 0, 0, 0, 1); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cap(16'h5555, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    // zero capacity
    amax = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    // gain
    amax = 3;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cap(16'h3000, 2, 0); cap(16'hf000, 3, 0); cap(16'h0010, 1, 0);
    idle(3);
    // random traffic
    begin
      logic lr = 0;
      for (int i = 0; i < 3000; i++) begin
        if (m_mode == M_IDLE && $urandom_range(0, 9) == 0) amax = $urandom_range(0, 6);
        if ($urandom_range(0, 2) == 0) lr = ~lr;
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0,
            lr, 16'($urandom), 2'($urandom), $urandom_range(0, 2) == 0);
      end
      cyc(0, 0, 1, 0, 0, 0, 0);
      idle(3);
    end
    // asynchronous reset during a pending write
    amax = 5;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 16'h4321, 0, 0);
    @(posedge clk);
    #1;
    chk("write_before_reset", 32'(o_mem_write), 32'd1);
    #1;
    rst_n = 1'b0;
    i_adclrck = 0; i_start = 0; i_mem_rdy = 0;
    #1;
    chk("rst_write", 32'(o_mem_write), 0);
    chk("rst_addr", 32'(o_mem_addr), 0);
    chk("rst_data", 32'(o_mem_data), 0);
    chk("rst_recording", 32'(o_recording), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    exp_q.delete();
    m_mode = M_IDLE; m_addr = 0; m_ovr = 0; m_prev = 0; e_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    amax = 2;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cap(16'h0777, 0, 0); cap(16'h0888, 0, 1);
    idle(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
